addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one registered add/sub unit (input register -> add/sub -> output register, 2-edge latency, op applied after the input register) between two requesters.
- Round-robin arbitration with valid/ready issue handshake, one issue per cycle.
- Drives the unit's operand/op inputs with correct op alignment.
- Tracks in-flight ops with a tag pipeline and returns each result to its owner.

Parameters:
- WIDTH, 8, operand/result width; must match the shared unit's width parameter.
- PIPE_LAT, 2, edges from issue to unit result valid; tag pipeline depth; legal values >= 2.

Ports:
- adderClock  in  1  single clock, rising edge
- resetNeg  in  1  synchronous, active-low reset
- arbEnable  in  1  1 = grants allowed; 0 = no new grants, in-flight ops drain
- req0Valid  in  1  requester 0 has an op
- req0Ready  out  1  requester 0 granted this cycle
- req0A, req0B  in  WIDTH  requester 0 operands
- req0Op  in  1  0 = add, 1 = subtract (A-B)
- req1Valid, req1Ready, req1A, req1B, req1Op  as above, requester 1
- aluA, aluB  out  WIDTH  to unit numA/numB
- aluOp  out  1  to unit opSelect
- aluSum  in  WIDTH  from unit sumFinal
- aluOverflow  in  1  from unit overflowBit
- rsp0Valid  out  1  one-cycle pulse, result for requester 0
- rsp1Valid  out  1  one-cycle pulse, result for requester 1
- rspSum  out  WIDTH  result, combinationally equal to aluSum
- rspOverflow  out  1  combinationally equal to aluOverflow
- inFlight  out  clog2(PIPE_LAT+1)  ops issued, result not yet returned

Behaviour:
- Reset (resetNeg=0 at edge): tag pipeline cleared, RR pointer = "requester 0 first", aluOp register = 0, counters = 0. Outputs: rsp*Valid = 0, req*Ready = 0 while resetNeg is low, inFlight = 0. The unit shares resetNeg.
- Grant is combinational from the current valids, arbEnable and the RR pointer. reqNReady = grantN. At most one grant per cycle.
- No grant if arbEnable = 0 or resetNeg = 0.
- Round-robin: pointer names the preferred requester. If only one is valid, it is granted. On any grant, the pointer moves to the other requester. With no grant, the pointer holds.
- Issue = reqNValid & reqNReady. The issue cycle drives aluA/aluB = granted operands, combinationally. No issue: aluA = aluB = 0.
- aluOp is a register loaded at the issue edge with the granted op. With no issue it loads 0. This aligns op with the unit's input register.
- Tag pipeline: PIPE_LAT stages of {valid, id}. Stage 0 is loaded at the issue edge; stages shift every edge.
- Final stage valid drives rsp{id}Valid for exactly one cycle, concurrent with the matching aluSum/aluOverflow.
- Latency: an op issued in cycle t returns in cycle t+PIPE_LAT.
- Throughput: 1 op/cycle. Alternating requests give back-to-back responses.
- No response backpressure; requesters must accept in the pulse cycle.
- inFlight: +1 on issue, -1 on response; unchanged if both occur in the same cycle. Maximum value PIPE_LAT.
- arbEnable falling mid-stream: in-flight ops complete normally and new issues stop.
- Reset mid-operation: all in-flight tags are dropped and no response pulses are produced for them.
- Requester holding valid without grant must hold operands; the arbiter samples only on issue.
- Arithmetic is the unit's: WIDTH-bit two's complement wrap, overflow = signed overflow. The arbiter does not modify data.

Optional Feature:
- Macro: ADDSUB_ARB_STATS_EN.
- Defined: adds outputs grantCnt0 and grantCnt1, each 16 bits, out. Each is incremented on its requester's issue, saturates at 16'hFFFF, and clears on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single op, WIDTH=8: reset, then req0 05+03 add, single cycle -> req0Ready=1 same cycle; aluOp=0 next cycle; rsp0Valid pulse 2 cycles after issue with rspSum=8'h08, rspOverflow=0; inFlight 0->1->2? no, 1,1,0.
- Contention: req0 and req1 valid continuously from reset -> grants 0,1,0,1. Req0 7F+01 -> rsp0 sum 8'h80 ovf=1. Req1 10-20 (op=1) -> rsp1 sum 8'hF0 ovf=0. Responses back-to-back, one per cycle.
- Subtract overflow on requester 1 alone: 80-01 -> rsp1Valid, sum 8'h7F, ovf=1. Pointer after grant prefers requester 0.
- arbEnable=0 for 4 cycles with both valid and 2 ops in flight -> both readies 0, 2 responses still delivered, inFlight reaches 0. Re-enable -> grant resumes at the pointer's requester.
- Reset mid-flight: issue req0 at cycle t, resetNeg=0 at t+1 -> no rsp0Valid pulse, inFlight=0, aluOp=0.
- ADDSUB_ARB_STATS_EN defined: 5 req0 and 3 req1 issues -> grantCnt0=5, grantCnt1=3. Counters clear on reset.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - requester, shared-unit and response signals of addsub_arbiter
interface addsub_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int PIPE_LAT = 2
);
  localparam int CW = $clog2(PIPE_LAT + 1);

  logic             arbEnable;
  logic             req0Valid;
  logic             req0Ready;
  logic [WIDTH-1:0] req0A;
  logic [WIDTH-1:0] req0B;
  logic             req0Op;
  logic             req1Valid;
  logic             req1Ready;
  logic [WIDTH-1:0] req1A;
  logic [WIDTH-1:0] req1B;
  logic             req1Op;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic             aluOp;
  logic [WIDTH-1:0] aluSum;
  logic             aluOverflow;
  logic             rsp0Valid;
  logic             rsp1Valid;
  logic [WIDTH-1:0] rspSum;
  logic             rspOverflow;
  logic [CW-1:0]    inFlight;

  modport slave (
    input  arbEnable, req0Valid, req0A, req0B, req0Op,
    input  req1Valid, req1A, req1B, req1Op, aluSum, aluOverflow,
    output req0Ready, req1Ready, aluA, aluB, aluOp,
    output rsp0Valid, rsp1Valid, rspSum, rspOverflow, inFlight
  );

  modport master (
    output arbEnable, req0Valid, req0A, req0B, req0Op,
    output req1Valid, req1A, req1B, req1Op, aluSum, aluOverflow,
    input  req0Ready, req1Ready, aluA, aluB, aluOp,
    input  rsp0Valid, rsp1Valid, rspSum, rspOverflow, inFlight
  );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one registered add/sub unit between two requesters
// Optional per-requester grant counters: define ADDSUB_ARB_STATS_EN.
module addsub_arbiter #(
  parameter int WIDTH    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic            adderClock,
  input  logic            resetNeg,
`ifdef ADDSUB_ARB_STATS_EN
  output logic [15:0]     grantCnt0,
  output logic [15:0]     grantCnt1,
`endif
  addsub_arbiter_if.slave bus
);
  localparam int CW = $clog2(PIPE_LAT + 1);

  logic                r_ptr;
  logic                r_alu_op;
  logic [PIPE_LAT-1:0] r_tag_v;
  logic [PIPE_LAT-1:0] r_tag_id;
  logic [CW-1:0]       r_in_flight;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_issue;
  logic                w_issue_id;
  logic                w_issue_op;
  logic                w_rsp;
  logic [WIDTH-1:0]    w_alu_a;
  logic [WIDTH-1:0]    w_alu_b;

  // r_ptr = 0 prefers requester 0; a lone valid requester always wins
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (resetNeg && bus.arbEnable) begin
      if (bus.req0Valid && (!r_ptr || !bus.req1Valid)) begin
        w_grant0 = 1'b1;
      end else if (bus.req1Valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_issue    = (bus.req0Valid & w_grant0) | (bus.req1Valid & w_grant1);
  assign w_issue_id = w_grant1;
  assign w_issue_op = w_grant1 ? bus.req1Op : bus.req0Op;
  assign w_alu_a    = w_grant0 ? bus.req0A : (w_grant1 ? bus.req1A : '0);
  assign w_alu_b    = w_grant0 ? bus.req0B : (w_grant1 ? bus.req1B : '0);
  assign w_rsp      = r_tag_v[PIPE_LAT-1];

  assign bus.req0Ready   = w_grant0;
  assign bus.req1Ready   = w_grant1;
  assign bus.aluA        = w_alu_a;
  assign bus.aluB        = w_alu_b;
  assign bus.aluOp       = r_alu_op;
  assign bus.rsp0Valid   = w_rsp & ~r_tag_id[PIPE_LAT-1];
  assign bus.rsp1Valid   = w_rsp & r_tag_id[PIPE_LAT-1];
  assign bus.rspSum      = bus.aluSum;
  assign bus.rspOverflow = bus.aluOverflow;
  assign bus.inFlight    = r_in_flight;

  // op is registered so it reaches the unit alongside its registered operands
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      r_ptr       <= 1'b0;
      r_alu_op    <= 1'b0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_in_flight <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= ~w_issue_id;
      end
      r_alu_op <= w_issue & w_issue_op;
      r_tag_v  <= {r_tag_v[PIPE_LAT-2:0], w_issue};
      r_tag_id <= {r_tag_id[PIPE_LAT-2:0], w_issue_id};
      case ({w_issue, w_rsp})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

`ifdef ADDSUB_ARB_STATS_EN
  always_ff @(posedge adderClock) begin
    if (!resetNeg) begin
      grantCnt0 <= '0;
      grantCnt1 <= '0;
    end else begin
      if (bus.req0Valid && w_grant0 && grantCnt0 != 16'hFFFF) begin
        grantCnt0 <= grantCnt0 + 16'd1;
      end
      if (bus.req1Valid && w_grant1 && grantCnt1 != 16'hFFFF) begin
        grantCnt1 <= grantCnt1 + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed bench for addsub_arbiter with a shared-unit model and response scoreboard
module tb_addsub_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  addsub_arbiter_if #(.WIDTH(8), .PIPE_LAT(2)) bus ();

`ifdef ADDSUB_ARB_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  addsub_arbiter #(.WIDTH(8), .PIPE_LAT(2)) dut (
    .adderClock (clk),
    .resetNeg   (rstn),
`ifdef ADDSUB_ARB_STATS_EN
    .grantCnt0  (cnt0),
    .grantCnt1  (cnt1),
`endif
    .bus        (bus)
  );

  // shared unit: input register, op applied after it, output register
  logic [7:0] u_a, u_b, u_res;
  logic       u_ovf;
  always_comb begin
    u_res = bus.aluOp ? (u_a - u_b) : (u_a + u_b);
    u_ovf = bus.aluOp ? ((u_a[7] ^ u_b[7]) & (u_res[7] ^ u_a[7]))
                      : (~(u_a[7] ^ u_b[7]) & (u_res[7] ^ u_a[7]));
  end
  always @(posedge clk) begin
    if (!rstn) begin
      u_a <= 8'h00; u_b <= 8'h00;
      bus.aluSum <= 8'h00; bus.aluOverflow <= 1'b0;
    end else begin
      u_a <= bus.aluA; u_b <= bus.aluB;
      bus.aluSum <= u_res; bus.aluOverflow <= u_ovf;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // signed arithmetic reference: {overflow, sum}
  function automatic logic [8:0] ref_op(logic [7:0] a, logic [7:0] b, logic op);
    int r;
    logic [7:0] s;
    r = op ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
    s = r[7:0];
    return {(r > 127 || r < -128), s};
  endfunction

  typedef struct {
    logic       id;
    logic [8:0] res;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      if (bus.rsp0Valid || bus.rsp1Valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {bus.rsp1Valid, bus.rsp0Valid}, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", {bus.rsp1Valid, bus.rsp0Valid}, e.id ? 2'b10 : 2'b01);
          chk("rsp_sum", bus.rspSum, e.res[7:0]);
          chk("rsp_ovf", bus.rspOverflow, e.res[8]);
          chk("rsp_latency", cyc, e.cyc + 2);
        end
      end
      if (bus.req0Valid && bus.req0Ready)
        sb.push_back('{1'b0, ref_op(bus.req0A, bus.req0B, bus.req0Op), cyc});
      if (bus.req1Valid && bus.req1Ready)
        sb.push_back('{1'b1, ref_op(bus.req1A, bus.req1B, bus.req1Op), cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(logic v, logic [7:0] a, logic [7:0] b, logic op);
    bus.req0Valid = v; bus.req0A = a; bus.req0B = b; bus.req0Op = op;
  endtask

  task automatic drv1(logic v, logic [7:0] a, logic [7:0] b, logic op);
    bus.req1Valid = v; bus.req1A = a; bus.req1B = b; bus.req1Op = op;
  endtask

  initial begin
    rstn = 1'b0;
    bus.arbEnable = 1'b1;
    drv0(1'b1, 8'h00, 8'h00, 1'b0);
    drv1(1'b0, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    chk("rst_ready0", bus.req0Ready, 0);
    chk("rst_rsp0", bus.rsp0Valid, 0);
    chk("rst_rsp1", bus.rsp1Valid, 0);
    chk("rst_inflight", bus.inFlight, 0);
    chk("rst_aluop", bus.aluOp, 0);
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    rstn = 1'b1;
    tick();

    // single add on requester 0
    drv0(1'b1, 8'h05, 8'h03, 1'b0);
    #1;
    chk("t1_ready0", bus.req0Ready, 1);
    chk("t1_alua", bus.aluA, 8'h05);
    chk("t1_alub", bus.aluB, 8'h03);
    tick();
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("t1_aluop", bus.aluOp, 0);
    chk("t1_inflight_a", bus.inFlight, 1);
    chk("t1_alua_idle", bus.aluA, 0);
    tick();
    chk("t1_rsp0", bus.rsp0Valid, 1);
    chk("t1_inflight_b", bus.inFlight, 1);
    tick();
    chk("t1_rsp0_end", bus.rsp0Valid, 0);
    chk("t1_inflight_c", bus.inFlight, 0);

    // contention from reset: grants alternate 0,1,0,1
    rstn = 1'b0;
    drv0(1'b1, 8'h7F, 8'h01, 1'b0);
    drv1(1'b1, 8'h10, 8'h20, 1'b1);
    tick(); tick();
    rstn = 1'b1;
    #1;
    chk("t2_g0_r0", bus.req0Ready, 1);
    chk("t2_g0_r1", bus.req1Ready, 0);
    tick();
    chk("t2_g1_r0", bus.req0Ready, 0);
    chk("t2_g1_r1", bus.req1Ready, 1);
    tick();
    chk("t2_g2_r0", bus.req0Ready, 1);
    chk("t2_inflight_max", bus.inFlight, 2);
    chk("t2_rsp0", bus.rsp0Valid, 1);
    tick();
    chk("t2_g3_r1", bus.req1Ready, 1);
    chk("t2_rsp1", bus.rsp1Valid, 1);
    tick();
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    drv1(1'b0, 8'h00, 8'h00, 1'b0);
    tick(); tick();
    chk("t2_drained", bus.inFlight, 0);

    // subtract overflow on requester 1 alone, then pointer prefers 0
    drv1(1'b1, 8'h80, 8'h01, 1'b1);
    #1;
    chk("t3_ready1", bus.req1Ready, 1);
    chk("t3_ready0", bus.req0Ready, 0);
    tick();
    chk("t3_aluop", bus.aluOp, 1);
    drv0(1'b1, 8'h22, 8'h11, 1'b0);
    drv1(1'b1, 8'h33, 8'h44, 1'b0);
    #1;
    chk("t3_ptr_r0", bus.req0Ready, 1);
    chk("t3_ptr_r1", bus.req1Ready, 0);
    tick();
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    drv1(1'b0, 8'h00, 8'h00, 1'b0);
    tick(); tick(); tick();
    chk("t3_drained", bus.inFlight, 0);

    // arbEnable low with two ops in flight
    drv0(1'b1, 8'h05, 8'h7B, 1'b1);
    drv1(1'b1, 8'h64, 8'h64, 1'b0);
    #1;
    chk("t4_c0_r1", bus.req1Ready, 1);
    tick();
    chk("t4_c1_r0", bus.req0Ready, 1);
    tick();
    bus.arbEnable = 1'b0;
    #1;
    chk("t4_dis_r0", bus.req0Ready, 0);
    chk("t4_dis_r1", bus.req1Ready, 0);
    chk("t4_dis_inflight", bus.inFlight, 2);
    tick();
    chk("t4_dis_r0b", bus.req0Ready, 0);
    tick(); tick();
    chk("t4_dis_drained", bus.inFlight, 0);
    chk("t4_dis_r1b", bus.req1Ready, 0);
    tick();
    bus.arbEnable = 1'b1;
    #1;
    chk("t4_resume_r1", bus.req1Ready, 1);
    chk("t4_resume_r0", bus.req0Ready, 0);
    tick();
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    drv1(1'b0, 8'h00, 8'h00, 1'b0);
    tick(); tick(); tick();

    // reset one cycle after issue drops the op
    drv0(1'b1, 8'h01, 8'h01, 1'b1);
    #1;
    chk("t5_ready0", bus.req0Ready, 1);
    tick();
    rstn = 1'b0;
    #1;
    chk("t5_rst_ready0", bus.req0Ready, 0);
    tick();
    rstn = 1'b1;
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("t5_inflight", bus.inFlight, 0);
    chk("t5_aluop", bus.aluOp, 0);
    chk("t5_rsp0_a", bus.rsp0Valid, 0);
    tick();
    chk("t5_rsp0_b", bus.rsp0Valid, 0);
    tick();

`ifdef ADDSUB_ARB_STATS_EN
    rstn = 1'b0;
    tick();
    chk("st_rst0", cnt0, 0);
    chk("st_rst1", cnt1, 0);
    rstn = 1'b1;
    drv0(1'b1, 8'h01, 8'h02, 1'b0);
    drv1(1'b1, 8'h03, 8'h04, 1'b1);
    repeat (6) tick();
    drv1(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) tick();
    drv0(1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("st_cnt0", cnt0, 5);
    chk("st_cnt1", cnt1, 3);
    tick(); tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("st_clr0", cnt0, 0);
    chk("st_clr1", cnt1, 0);
    tick();
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
